// File: rtl/plot_sequencer.sv
// rtl/plot_sequencer.sv - frame-buffer clear and single-sweep sine plot sequencer
module plot_sequencer #(
    parameter int          WIDTH    = 160,
    parameter int          HEIGHT   = 120,
    parameter int          ADDR_W   = 15,
    parameter logic [11:0] BG_COLOR = 12'h000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              auto,
    input  logic              frame_sync,
    input  logic [7:0]        plot_x,
    input  logic [7:0]        plot_y,
    input  logic [11:0]       plot_color,
    output logic              plot_en,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [11:0]       fb_data,
    output logic              fb_we,
    output logic              busy,
    output logic              done,
    output logic              clipped
);

    localparam logic [ADDR_W-1:0] LAST_PIX   = ADDR_W'(WIDTH * HEIGHT - 1);
    localparam logic [ADDR_W-1:0] LAST_COL   = ADDR_W'(WIDTH - 1);
    localparam logic [ADDR_W-1:0] LAST_DRAIN = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ROW_PITCH  = ADDR_W'(WIDTH);
    localparam logic [7:0]        Y_LIMIT    = 8'(HEIGHT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SYNC,
        S_CLEAR,
        S_PLOT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_nx;
    logic              clr_clip;

    // Stage 1: column index delayed to line up with the plotter's ROM sample
    logic [7:0]        s1_x;
    logic              s1_valid;

    // Stage 2: registered plot write
    logic [ADDR_W-1:0] wr_addr;
    logic [11:0]       wr_data;
    logic              wr_we;

    logic [ADDR_W-1:0] addr_calc;
    logic              in_range;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        clr_clip = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_WAIT_SYNC;
                    cnt_nx   = '0;
                    clr_clip = 1'b1;
                end
            end
            S_WAIT_SYNC: begin
                if (frame_sync) begin
                    state_nx = S_CLEAR;
                    cnt_nx   = '0;
                end
            end
            S_CLEAR: begin
                if (cnt == LAST_PIX) begin
                    state_nx = S_PLOT;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            S_PLOT: begin
                if (cnt == LAST_COL) begin
                    state_nx = S_DRAIN;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            S_DRAIN: begin
                if (cnt == LAST_DRAIN) begin
                    state_nx = S_DONE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            S_DONE: begin
                cnt_nx = '0;
                if (auto) begin
                    state_nx = S_WAIT_SYNC;
                    clr_clip = 1'b1;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    assign busy    = (state != S_IDLE);
    assign plot_en = (state == S_PLOT);
    assign done    = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_x     <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_x     <= plot_x;
            s1_valid <= plot_en;
        end
    end

    // Address wraps harmlessly for clipped samples since they never write
    assign addr_calc = ADDR_W'(plot_y) * ROW_PITCH + ADDR_W'(s1_x);
    assign in_range  = (plot_y < Y_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_addr <= '0;
            wr_data <= '0;
            wr_we   <= 1'b0;
        end else begin
            wr_we <= s1_valid && in_range;
            if (s1_valid) begin
                wr_addr <= addr_calc;
                wr_data <= plot_color;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clipped <= 1'b0;
        end else if (clr_clip) begin
            clipped <= 1'b0;
        end else if (s1_valid && !in_range) begin
            clipped <= 1'b1;
        end
    end

    // Clear and plot phases are disjoint in time, so a simple mux suffices
    always_comb begin
        fb_we   = wr_we;
        fb_addr = wr_addr;
        fb_data = wr_data;
        if (state == S_CLEAR) begin
            fb_we   = 1'b1;
            fb_addr = cnt;
            fb_data = BG_COLOR;
        end
    end

endmodule
